// File: rtl/muldiv_divider_if.sv
// Handshake and data bundle between the EX stage and the 32-bit divider.
interface muldiv_divider_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        kill;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  // Pipeline side: issues requests and flushes, consumes status and result.
  modport master (
    output start, funct3, operand1, operand2, kill,
    input  busy, stall, done, result
  );

  // Divider side.
  modport slave (
    input  start, funct3, operand1, operand2, kill,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_divider.sv
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU.
// Normal operations take 32 CALC steps; divide-by-zero and signed overflow
// take a one-cycle SPEC path with a precomputed result.
module muldiv_divider (
  input  logic              clk,
  input  logic              rst,
  muldiv_divider_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPEC = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic [63:0] rq_r;          // {partial remainder, dividend/quotient}
  logic [31:0] divisor_r;
  logic        sign1_r;       // dividend negative (signed ops only)
  logic        sign2_r;       // divisor negative (signed ops only)
  logic        rem_r;         // 1: return remainder, 0: return quotient
  logic [31:0] spec_res_r;    // result prepared for the SPEC path
  logic [31:0] result_r;
  logic        busy_r;
  logic        done_r;

  logic        accept_s;
  logic        is_signed_s;
  logic        neg1_s;
  logic        neg2_s;
  logic [31:0] abs1_s;
  logic [31:0] abs2_s;
  logic        div0_s;
  logic        ovf_s;
  logic [64:0] sh_s;
  logic [32:0] diff_s;
  logic [63:0] step_s;
  logic [31:0] q_fix_s;
  logic [31:0] r_fix_s;
  logic [31:0] fin_s;

  // Only the 1x0 encodings (DIV, REM) are signed.
  assign is_signed_s = bus.funct3[2] & ~bus.funct3[0];
  assign neg1_s      = is_signed_s & bus.operand1[31];
  assign neg2_s      = is_signed_s & bus.operand2[31];
  assign abs1_s      = neg1_s ? (32'd0 - bus.operand1) : bus.operand1;
  assign abs2_s      = neg2_s ? (32'd0 - bus.operand2) : bus.operand2;
  assign div0_s      = (bus.operand2 == 32'd0);
  assign ovf_s       = is_signed_s & (bus.operand1 == 32'h8000_0000) &
                       (bus.operand2 == 32'hFFFF_FFFF);
  assign accept_s    = (state_r == IDLE) & bus.start & ~bus.kill;

  // One restoring step: shift left, subtract when the upper 33 bits cover the divisor.
  always_comb begin
    sh_s   = {rq_r, 1'b0};
    diff_s = sh_s[64:32] - {1'b0, divisor_r};
    if (sh_s[64:32] >= {1'b0, divisor_r}) begin
      step_s = {diff_s[31:0], sh_s[31:1], 1'b1};
    end else begin
      step_s = sh_s[63:0];
    end
  end

  // Sign fix-up on the final step: quotient negative when signs differ,
  // remainder follows the dividend.
  always_comb begin
    q_fix_s = (sign1_r ^ sign2_r) ? (32'd0 - step_s[31:0]) : step_s[31:0];
    r_fix_s = sign1_r ? (32'd0 - step_s[63:32]) : step_s[63:32];
    if (rem_r) begin
      fin_s = r_fix_s;
    end else begin
      fin_s = q_fix_s;
    end
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 6'd0;
      rq_r       <= 64'd0;
      divisor_r  <= 32'd0;
      sign1_r    <= 1'b0;
      sign2_r    <= 1'b0;
      rem_r      <= 1'b0;
      spec_res_r <= 32'd0;
      result_r   <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.kill) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.start) begin
              rem_r     <= bus.funct3[1];
              sign1_r   <= neg1_s;
              sign2_r   <= neg2_s;
              rq_r      <= {32'd0, abs1_s};
              divisor_r <= abs2_s;
              busy_r    <= 1'b1;
              if (div0_s) begin
                // Quotient all ones; remainder is the untouched dividend.
                spec_res_r <= bus.funct3[1] ? bus.operand1 : 32'hFFFF_FFFF;
                state_r    <= SPEC;
              end else if (ovf_s) begin
                spec_res_r <= bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
                state_r    <= SPEC;
              end else begin
                cnt_r   <= 6'd0;
                state_r <= CALC;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          SPEC: begin
            result_r <= spec_res_r;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= DONE;
          end
          CALC: begin
            rq_r  <= step_s;
            cnt_r <= cnt_r + 6'd1;
            if (cnt_r == 6'd31) begin
              result_r <= fin_s;
              done_r   <= 1'b1;
              busy_r   <= 1'b0;
              state_r  <= DONE;
            end else begin
              state_r <= CALC;
            end
          end
          DONE: begin
            state_r <= IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  // Stall already in the accepting cycle; drops in DONE so the result advances.
  assign bus.stall  = accept_s | busy_r;

endmodule

// File: tb/tb_muldiv_divider.sv
// Self-checking bench for muldiv_divider: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_divider;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_bad    = 0;

  muldiv_divider_if bus ();

  muldiv_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit arithmetic sidesteps the signed-overflow corner.
  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    case (f)
      3'b100:  r = sa / sb;
      3'b101:  r = ua / ub;
      3'b110:  r = sa % sb;
      3'b111:  r = ua % ub;
      default: r = 64'sd0;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 33;
  endfunction

  // Issue one operation and check stall, latency, result, done width and hold.
  // dup_at > 1 pulses a second (ignored) start with other operands at that cycle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int dup_at, input bit no_sync);
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    exp_r   = ref_div(f, a, b);
    exp_lat = ref_lat(f, a, b);
    if (!no_sync) @(negedge clk);
    check_val({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, ".idle_done"}, 32'(bus.done), 32'd0);
    bus.kill     = 1'b0;
    bus.start    = 1'b1;
    bus.funct3   = f;
    bus.operand1 = a;
    bus.operand2 = b;
    #1;
    check_val({tag, ".stall_t"}, 32'(bus.stall), 32'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = (k == dup_at);
      if (k == dup_at) begin
        bus.funct3   = 3'b101;
        bus.operand1 = ~a;
        bus.operand2 = b + 32'd5;
      end
      if (k == 1) begin
        check_val({tag, ".busy1"}, 32'(bus.busy), 32'd1);
        check_val({tag, ".stall1"}, 32'(bus.stall), 32'd1);
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    if (lat > 0) begin
      check_val({tag, ".result"}, bus.result, exp_r);
      check_val({tag, ".stall_done"}, 32'(bus.stall), 32'd0);
      check_val({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check_val({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
      check_val({tag, ".hold"}, bus.result, exp_r);
    end
  endtask

  logic [31:0] prev_res;
  logic [31:0] ra, rb;
  logic [2:0]  rf;

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.kill     = 1'b0;
    bus.funct3   = 3'b100;
    bus.operand1 = 32'd0;
    bus.operand2 = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst.busy", 32'(bus.busy), 32'd0);
    check_val("rst.done", 32'(bus.done), 32'd0);
    check_val("rst.result", bus.result, 32'd0);
    check_val("rst.stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;

    // Directed cases.
    run_op("divu100_7", 3'b101, 32'd100, 32'd7, 0, 1'b0);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op("remu_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op("div5_0", 3'b100, 32'd5, 32'd0, 0, 1'b0);
    run_op("remu5_0", 3'b111, 32'd5, 32'd0, 0, 1'b0);
    run_op("rem_m5_0", 3'b110, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("dup_start", 3'b101, 32'd100, 32'd7, 3, 1'b0);

    // Kill mid-CALC, then a new request in the cycle after.
    prev_res = bus.result;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = 3'b101;
    bus.operand1 = 32'd1000;
    bus.operand2 = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check_val("kill.no_done", 32'(bus.done), 32'd0);
      if (k == 10) bus.kill = 1'b1;
    end
    @(negedge clk);
    check_val("kill.busy", 32'(bus.busy), 32'd0);
    check_val("kill.done", 32'(bus.done), 32'd0);
    check_val("kill.result", bus.result, prev_res);
    run_op("after_kill", 3'b101, 32'd9, 32'd3, 0, 1'b1);

    // Kill takes priority over start in IDLE.
    @(negedge clk);
    bus.kill  = 1'b1;
    bus.start = 1'b1;
    #1;
    check_val("killstart.stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check_val("killstart.busy", 32'(bus.busy), 32'd0);
    bus.kill  = 1'b0;
    bus.start = 1'b0;

    // Reset mid-CALC with an ignored second start.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = 3'b101;
    bus.operand1 = 32'd50;
    bus.operand2 = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = (k == 3);
      check_val("rstmid.no_done", 32'(bus.done), 32'd0);
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    check_val("rstmid.busy", 32'(bus.busy), 32'd0);
    check_val("rstmid.done", 32'(bus.done), 32'd0);
    check_val("rstmid.result", bus.result, 32'd0);
    rst = 1'b0;
    run_op("after_rst", 3'b110, 32'd50, 32'd7, 0, 1'b0);

    // Randomized operations with biased corner selection.
    for (int i = 0; i < 150; i++) begin
      rf = {1'b1, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       ra = 32'($urandom_range(0, 15));
        4:       rb = ra;
        default: rb = $urandom;
      endcase
      run_op("rand", rf, ra, rb, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_divider.md
MULDIV_DIVIDER -- requirements
Module: muldiv_divider

Interface
REQ-001 The module SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a divide using the current funct3/operand1/operand2.
REQ-005 funct3  input  3  operation select: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
REQ-006 operand1  input  32  dividend (rs1, post-forwarding EX operand).
REQ-007 operand2  input  32  divisor (rs2, post-forwarding EX operand).
REQ-008 kill  input  1  pipeline flush; abort any operation in progress.
REQ-009 busy  output  1  operation in progress (state CALC or SPEC).
REQ-010 stall  output  1  hold IF/ID/EX pipeline registers.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  32  quotient or remainder per funct3.

Function
REQ-013 The FSM SHALL have states IDLE, SPEC, CALC and DONE.
REQ-014 In IDLE with start=1 and kill=0, the block SHALL latch funct3, |operand1| and |operand2| (absolute values for DIV/REM, raw for DIVU/REMU) and both sign bits.
REQ-015 With divisor==0 or signed overflow (DIV/REM, operand1=0x80000000, operand2=0xFFFFFFFF), the next state SHALL be SPEC; otherwise it SHALL be CALC with a 6-bit counter cleared to 0.
REQ-016 CALC SHALL perform one restoring radix-2 step per cycle, shifting the 64-bit remainder/quotient register left, subtracting the divisor when the upper 33 bits are >= divisor and setting the quotient LSB; it SHALL exit to DONE after exactly 32 steps.
REQ-017 SPEC SHALL last one cycle and then go to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, result SHALL be valid, and the next state SHALL be IDLE.
REQ-019 Latency: start accepted at cycle T gives done at T+33 for normal operations and T+2 for special cases.
REQ-020 Signed quotient SHALL be negated when the operand signs differ; signed remainder SHALL take the sign of the dividend.
REQ-021 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = operand1 (unmodified), for both signed and unsigned operations.
REQ-022 Signed overflow SHALL give quotient 0x80000000 and remainder 0x00000000.
REQ-023 result SHALL be registered and SHALL hold its value after done until the next DONE or reset.
REQ-024 stall SHALL equal (state==IDLE & start & ~kill) | busy, computed combinationally; it SHALL be 0 in the DONE cycle so the instruction advances with the result.
REQ-025 start SHALL be ignored in SPEC, CALC and DONE; operands SHALL be sampled only at acceptance.
REQ-026 kill=1 in any state SHALL force IDLE on the next edge, with no done pulse and result unchanged; kill takes priority over start in IDLE.
REQ-027 busy SHALL be 1 exactly in the SPEC and CALC states.

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge regardless of state, and SHALL clear the counter, result (0x00000000), done (0) and busy (0).
REQ-029 rst SHALL take priority over kill and start.
REQ-030 A reset asserted mid-CALC SHALL discard the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-031 DIVU, operand1=100, operand2=7, start at T -> stall=1 from T; done=1 and result=14 at T+33; stall=0 at T+33.
REQ-032 DIV operand1=0xFFFFFFF9 (-7), operand2=2 -> result 0xFFFFFFFD; REM with the same operands -> result 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> result 0x00000001.
REQ-033 DIV 5/0 -> done at T+2, result 0xFFFFFFFF; REMU 5/0 -> result 0x00000005.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> result 0x80000000 at T+2; REM with the same operands -> result 0x00000000.
REQ-035 Start DIVU at T, kill at T+10 -> busy=0 at T+11, no done pulse; a new DIVU 9/3 started at T+11 -> result 3 at T+44.
REQ-036 Start at T, rst at T+5 -> busy=0, done=0, result=0 at T+6; start ignored while busy (second start at T+3 has no effect).
